// File: rtl/sma_window_shift_reg_pkg.sv
// sma_pkg: shared constants, width helpers and sample type for the SMA path.
// No ports; imported by the window register, its interface and its stages.
package sma_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    typedef logic [DEF_WIDTH-1:0] sample_t;

    // Exactly wide enough for depth * (2^width - 1).
    function automatic int sum_w(input int width, input int depth);
        return width + $clog2(depth);
    endfunction

    // Holds the values 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sma_window_shift_reg_if.sv
// sma_window_shift_reg_if: sample-in / window-out bundle for the SMA window.
// master drives enable, flush, dataIn; slave drives dataOut, taps, sum, count, full.
interface sma_window_shift_reg_if
    import sma_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int SUM_W = sum_w(WIDTH, DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic                   enable;
    logic                   flush;
    logic [WIDTH-1:0]       dataIn;
    logic [WIDTH-1:0]       dataOut;
    logic [DEPTH*WIDTH-1:0] taps;
    logic [SUM_W-1:0]       sum;
    logic [CNT_W-1:0]       count;
    logic                   full;

    modport master (
        output enable, flush, dataIn,
        input  dataOut, taps, sum, count, full
    );

    modport slave (
        input  enable, flush, dataIn,
        output dataOut, taps, sum, count, full
    );

endinterface

// File: rtl/sma_window_shift_reg_window_stage.sv
// window_stage: one WIDTH-bit window register; clear beats enable.
// Ports: clk, reset (sync, active-low), clear, enable, d, q.
module window_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sma_window_shift_reg.sv
// sma_window_shift_reg: DEPTH-sample shift window with running sum and fill count.
// Ports: clk, reset (sync, active-low), bus (slave: enable/flush/dataIn in; taps/sum/count/full/dataOut out).
module sma_window_shift_reg
    import sma_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    sma_window_shift_reg_if.slave bus
);

    localparam int SUM_W = sum_w(WIDTH, DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
    logic [SUM_W:0]   acc;
    logic [CNT_W-1:0] count_q;

    // Stage 0 takes the new sample; each later stage takes its neighbour.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            window_stage #(.WIDTH(WIDTH)) u_stage (
                .clk    (clk),
                .reset  (reset),
                .clear  (bus.flush),
                .enable (bus.enable),
                .d      (bus.dataIn),
                .q      (stage[k])
            );
        end else begin : g_body
            window_stage #(.WIDTH(WIDTH)) u_stage (
                .clk    (clk),
                .reset  (reset),
                .clear  (bus.flush),
                .enable (bus.enable),
                .d      (stage[k-1]),
                .q      (stage[k])
            );
        end
        assign bus.taps[k*WIDTH +: WIDTH] = stage[k];
    end

    // Evicted stage is zero until the window fills, so one formula
    // covers both filling and sliding. The extra bit absorbs the
    // intermediate add; a set top bit cannot occur and clamps to 0.
    always_comb begin
        acc = {1'b0, sum_q}
            + (SUM_W+1)'(bus.dataIn)
            - (SUM_W+1)'(stage[DEPTH-1]);
        sum_d = acc[SUM_W] ? '0 : acc[SUM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q   <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            sum_q   <= '0;
            count_q <= '0;
        end else if (bus.enable) begin
            sum_q <= sum_d;
            if (count_q != CNT_W'(DEPTH)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.sum     = sum_q;
    assign bus.count   = count_q;
    assign bus.full    = (count_q == CNT_W'(DEPTH));
    assign bus.dataOut = stage[DEPTH-1];

endmodule

// File: tb/tb_sma_window_shift_reg.sv
// tb_sma_window_shift_reg: directed checks of the SMA window at WIDTH=8, DEPTH=4.
// Drives the interface master side; prints a single summary line.
module tb_sma_window_shift_reg;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sma_window_shift_reg_if #(.WIDTH(8), .DEPTH(4)) bus ();

    sma_window_shift_reg #(.WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        bus.enable = 1'b1;
        bus.flush  = 1'b0;
        bus.dataIn = v;
        tick();
        bus.enable = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush  = 1'b1;
        bus.enable = 1'b0;
        tick();
        bus.flush  = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        bus.enable = 1'b1;
        bus.flush  = 1'b0;
        bus.dataIn = 8'hFF;
        tick();
        tick();
        checks++;
        if (bus.taps !== 32'h0) begin
            errors++;
            $display("FAIL reset_taps got=%h exp=%h", bus.taps, 32'h0);
        end
        checks++;
        if (bus.sum !== 10'd0) begin
            errors++;
            $display("FAIL reset_sum got=%0d exp=0", bus.sum);
        end
        checks++;
        if (bus.count !== 3'd0 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL reset_count got=%0d/%b exp=0/0", bus.count, bus.full);
        end
        checks++;
        if (bus.dataOut !== 8'd0) begin
            errors++;
            $display("FAIL reset_dataout got=%0d exp=0", bus.dataOut);
        end
        bus.enable = 1'b0;
        reset      = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        logic [7:0] vals [4];
        logic [9:0] esum [4];
        vals = '{8'd10, 8'd20, 8'd30, 8'd40};
        esum = '{10'd10, 10'd30, 10'd60, 10'd100};
        for (int i = 0; i < 4; i++) begin
            push(vals[i]);
            checks++;
            if (bus.sum !== esum[i] || bus.count !== 3'(i + 1)) begin
                errors++;
                $display("FAIL fill_%0d got sum=%0d cnt=%0d exp sum=%0d cnt=%0d",
                         i, bus.sum, bus.count, esum[i], i + 1);
            end
            checks++;
            if (bus.full !== (i == 3)) begin
                errors++;
                $display("FAIL fill_full_%0d got=%b exp=%b", i, bus.full, i == 3);
            end
        end
        checks++;
        if (bus.taps !== {8'd10, 8'd20, 8'd30, 8'd40}) begin
            errors++;
            $display("FAIL fill_taps got=%h exp=0a141e28", bus.taps);
        end
        checks++;
        if (bus.dataOut !== 8'd10) begin
            errors++;
            $display("FAIL fill_dataout got=%0d exp=10", bus.dataOut);
        end
    endtask

    task automatic test_evict_hold();
        push(8'd50);
        checks++;
        if (bus.sum !== 10'd140 || bus.dataOut !== 8'd20) begin
            errors++;
            $display("FAIL evict got sum=%0d out=%0d exp sum=140 out=20",
                     bus.sum, bus.dataOut);
        end
        checks++;
        if (bus.count !== 3'd4 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL evict_count got=%0d/%b exp=4/1", bus.count, bus.full);
        end
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.dataIn = (i % 2 == 0) ? 8'hA5 : 8'h5A;
            tick();
            checks++;
            if (bus.taps !== {8'd20, 8'd30, 8'd40, 8'd50} ||
                bus.sum !== 10'd140 || bus.count !== 3'd4 ||
                bus.full !== 1'b1 || bus.dataOut !== 8'd20) begin
                errors++;
                $display("FAIL hold_%0d got taps=%h sum=%0d cnt=%0d full=%b out=%0d exp taps=141e2832 sum=140 cnt=4 full=1 out=20",
                         i, bus.taps, bus.sum, bus.count, bus.full, bus.dataOut);
            end
        end
    endtask

    task automatic test_max();
        do_flush();
        for (int i = 0; i < 4; i++) push(8'd255);
        checks++;
        if (bus.sum !== 10'd1020 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL max_sum got sum=%0d full=%b exp sum=1020 full=1",
                     bus.sum, bus.full);
        end
        push(8'd0);
        checks++;
        if (bus.sum !== 10'd765 || bus.count !== 3'd4) begin
            errors++;
            $display("FAIL max_evict got sum=%0d cnt=%0d exp sum=765 cnt=4",
                     bus.sum, bus.count);
        end
    endtask

    task automatic test_flush();
        bus.flush  = 1'b1;
        bus.enable = 1'b1;
        bus.dataIn = 8'd7;
        tick();
        bus.flush  = 1'b0;
        bus.enable = 1'b0;
        checks++;
        if (bus.sum !== 10'd0 || bus.count !== 3'd0 ||
            bus.taps !== 32'h0 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL flush got sum=%0d cnt=%0d taps=%h full=%b exp 0/0/0/0",
                     bus.sum, bus.count, bus.taps, bus.full);
        end
        push(8'd7);
        checks++;
        if (bus.sum !== 10'd7 || bus.count !== 3'd1) begin
            errors++;
            $display("FAIL flush_resume got sum=%0d cnt=%0d exp sum=7 cnt=1",
                     bus.sum, bus.count);
        end
    endtask

    task automatic test_reset_midfill();
        do_flush();
        push(8'd5);
        push(8'd6);
        checks++;
        if (bus.sum !== 10'd11 || bus.count !== 3'd2) begin
            errors++;
            $display("FAIL midfill got sum=%0d cnt=%0d exp sum=11 cnt=2",
                     bus.sum, bus.count);
        end
        reset      = 1'b0;
        bus.enable = 1'b1;
        bus.dataIn = 8'd33;
        tick();
        reset      = 1'b1;
        bus.enable = 1'b0;
        push(8'd9);
        checks++;
        if (bus.sum !== 10'd9 || bus.count !== 3'd1 ||
            bus.taps !== {8'd0, 8'd0, 8'd0, 8'd9}) begin
            errors++;
            $display("FAIL midfill_reset got sum=%0d cnt=%0d taps=%h exp sum=9 cnt=1 taps=00000009",
                     bus.sum, bus.count, bus.taps);
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.flush  = 1'b0;
        bus.dataIn = '0;
        test_reset();
        test_fill();
        test_evict_hold();
        test_max();
        test_flush();
        test_reset_midfill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
